// File: rtl/alu_result_buffer.sv
// ALU result buffer: circular FIFO of {flags, data} entries
// with drop counting and a sticky overflow flag.
module alu_result_buffer #(
    parameter int DEPTH = 4,
    parameter int DW    = 8,
    parameter int FW    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       in_valid,
    input  logic [DW-1:0]              in_data,
    input  logic [FW-1:0]              in_flags,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DW-1:0]              out_data,
    output logic [FW-1:0]              out_flags,
    output logic [$clog2(DEPTH):0]     count,
    output logic [3:0]                 drop_cnt,
    output logic                       ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [FW+DW-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;
    logic             drop;

    // Ready/valid come from the registered count only.
    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign drop      = in_valid && !in_ready;

    assign {out_flags, out_data} = mem[rd_ptr];

    // Entry storage; deliberately not reset.
    always_ff @(posedge clk) begin
        if (push && !rst && !clr) begin
            mem[wr_ptr] <= {in_flags, in_data};
        end
    end

    // Pointers, occupancy and drop bookkeeping; rst over clr over traffic.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
            ovf      <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                ovf <= 1'b1;
                if (drop_cnt != 4'hF) begin
                    drop_cnt <= drop_cnt + 1'b1;
                end
            end
        end
    end

endmodule
